// File: rtl/mult_pkg.sv
// Shared types and helpers for the pipelined multiply-accumulate datapath.
// Widths are passed in as ints so one set of helpers serves every instance.
package mult_pkg;

  localparam int MAXW = 64;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } stage_tag_t;

  function automatic int acc_width(input int wl_a, input int wl_b, input int guard);
    return wl_a + wl_b + guard;
  endfunction

  function automatic logic signed [MAXW-1:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [MAXW-1:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Round-half-up arithmetic shift, then clamp to a wl_out-bit signed range.
  function automatic logic signed [MAXW-1:0] round_sat(
    input  logic signed [MAXW-1:0] sum,
    input  int                     shift,
    input  int                     wl_out,
    output logic                   flag
  );
    logic signed [MAXW-1:0] r;
    r    = sum;
    flag = 1'b0;
    if (shift > 0) r = (sum + (64'sd1 <<< (shift - 1))) >>> shift;
    if (r > sat_max(wl_out)) begin
      r    = sat_max(wl_out);
      flag = 1'b1;
    end else if (r < sat_min(wl_out)) begin
      r    = sat_min(wl_out);
      flag = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_round_sat.sv
// Combinational scale/round/saturate from accumulator width to output width.
module mult_round_sat
  import mult_pkg::*;
#(
  parameter int WL_ACC     = 13,
  parameter int WL_OUT     = 9,
  parameter int FRAC_SHIFT = 0
) (
  input  logic signed [WL_ACC-1:0] sum,
  output logic signed [WL_OUT-1:0] res,
  output logic                     clamp
);

  logic signed [MAXW-1:0] r;
  logic                   unused_hi;

  always_comb begin
    r   = round_sat(MAXW'(sum), FRAC_SHIFT, WL_OUT, clamp);
    res = r[WL_OUT-1:0];
  end

  // Upper bits are sign copies after the clamp.
  assign unused_hi = ^r[MAXW-1:WL_OUT];

endmodule

// File: rtl/mult_acc_pipe.sv
// Pipelined signed multiply-accumulate with framed sums, rounding and saturation.
// One global enable freezes every stage while a result waits for the consumer.
module mult_acc_pipe
  import mult_pkg::*;
#(
  parameter int WL_A       = 4,
  parameter int WL_B       = 5,
  parameter int WL_OUT     = 9,
  parameter int FRAC_SHIFT = 0,
  parameter int GUARD      = 4,
  parameter int PIPE       = 2
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [WL_A-1:0]   in_a,
  input  logic signed [WL_B-1:0]   in_b,
  input  logic                     in_first,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [WL_OUT-1:0] out,
  output logic                     out_sat
);

  localparam int WL_P   = WL_A + WL_B;
  localparam int WL_ACC = acc_width(WL_A, WL_B, GUARD);
  localparam logic signed [WL_ACC-1:0] ACC_MAX = WL_ACC'(sat_max(WL_ACC));
  localparam logic signed [WL_ACC-1:0] ACC_MIN = WL_ACC'(sat_min(WL_ACC));

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Product pipeline
  stage_tag_t                  tag_in;
  logic signed [WL_P-1:0]      prod_in;
  stage_tag_t [PIPE:1]         tag_pipe;
  logic [PIPE:1][WL_P-1:0]     prod_pipe;

  assign tag_in  = '{valid: in_valid, first: in_first, last: in_last};
  assign prod_in = in_a * in_b;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tag_pipe  <= '0;
      prod_pipe <= '0;
    end else if (en) begin
      tag_pipe[1]  <= tag_in;
      prod_pipe[1] <= prod_in;
      for (int s = 2; s <= PIPE; s++) begin
        tag_pipe[s]  <= tag_pipe[s-1];
        prod_pipe[s] <= prod_pipe[s-1];
      end
    end
  end

  // Accumulate stage
  stage_tag_t                tag_p;
  logic signed [WL_P-1:0]    p;
  logic signed [WL_ACC-1:0]  acc, acc_base, acc_sum, sum_q;
  logic signed [WL_ACC:0]    acc_wide;
  logic                      acc_sat, sat_base, acc_ovf, sum_sat_q, last_q;

  assign tag_p = tag_pipe[PIPE];
  assign p     = $signed(prod_pipe[PIPE]);

  // One extra bit holds the exact sum so overflow is a simple range test.
  always_comb begin
    acc_base = tag_p.first ? '0 : acc;
    sat_base = tag_p.first ? 1'b0 : acc_sat;
    acc_wide = (WL_ACC+1)'(acc_base) + (WL_ACC+1)'(p);
    acc_sum  = acc_wide[WL_ACC-1:0];
    acc_ovf  = 1'b0;
    if (acc_wide > (WL_ACC+1)'(ACC_MAX)) begin
      acc_sum = ACC_MAX;
      acc_ovf = 1'b1;
    end else if (acc_wide < (WL_ACC+1)'(ACC_MIN)) begin
      acc_sum = ACC_MIN;
      acc_ovf = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc       <= '0;
      acc_sat   <= 1'b0;
      sum_q     <= '0;
      sum_sat_q <= 1'b0;
      last_q    <= 1'b0;
    end else if (en) begin
      last_q <= tag_p.valid && tag_p.last;
      if (tag_p.valid) begin
        if (tag_p.last) begin
          sum_q     <= acc_sum;
          sum_sat_q <= sat_base || acc_ovf;
          acc       <= '0;
          acc_sat   <= 1'b0;
        end else begin
          acc     <= acc_sum;
          acc_sat <= sat_base || acc_ovf;
        end
      end
    end
  end

  // Output stage
  logic signed [WL_OUT-1:0] rs_res;
  logic                     rs_clamp;

  mult_round_sat #(
    .WL_ACC    (WL_ACC),
    .WL_OUT    (WL_OUT),
    .FRAC_SHIFT(FRAC_SHIFT)
  ) u_round_sat (
    .sum  (sum_q),
    .res  (rs_res),
    .clamp(rs_clamp)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out       <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= last_q;
      if (last_q) begin
        out     <= rs_res;
        out_sat <= rs_clamp || sum_sat_q;
      end
    end
  end

endmodule

// File: tb/tb_mult_acc_pipe.sv
// Four parameter variants share one stimulus stream; a frame-level arithmetic
// model predicts each variant's result and a scoreboard matches them in order.
module tb_mult_acc_pipe;

  localparam int PIPE = 2;
  localparam int LAT  = PIPE + 2;
  localparam int CFG_WO [4] = '{9, 6, 9, 9};
  localparam int CFG_FS [4] = '{0, 0, 2, 0};
  localparam int CFG_GD [4] = '{4, 4, 4, 0};

  logic              clock = 1'b0;
  logic              resetn;
  logic              in_valid, in_first, in_last;
  logic signed [3:0] in_a;
  logic signed [4:0] in_b;
  logic              out_ready = 1'b1;
  wire  [3:0]        rdy, ov, os;
  logic signed [15:0] outs [4];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic signed [CFG_WO[g]-1:0] o;
    mult_acc_pipe #(
      .WL_A(4), .WL_B(5), .WL_OUT(CFG_WO[g]), .FRAC_SHIFT(CFG_FS[g]),
      .GUARD(CFG_GD[g]), .PIPE(PIPE)
    ) u_dut (
      .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(rdy[g]),
      .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
      .out_valid(ov[g]), .out_ready(out_ready), .out(o), .out_sat(os[g])
    );
    assign outs[g] = 16'(o);
  end

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model
  typedef struct packed {
    int              cyc;
    logic            chk;
    logic [3:0][15:0] val;
    logic [3:0]      sat;
  } exp_t;

  exp_t expq [$];
  int   fa [$], fb [$];
  logic chk_lat = 1'b0;

  function automatic exp_t model_frame(input int c, input logic chk);
    exp_t   e;
    longint s, hi, lo, ohi;
    logic   st;
    e.cyc = c; e.chk = chk; e.val = '0; e.sat = '0;
    for (int i = 0; i < 4; i++) begin
      hi = (longint'(1) <<< (8 + CFG_GD[i])) - 1;
      lo = -hi - 1;
      s  = 0;
      st = 1'b0;
      foreach (fa[k]) begin
        s = s + fa[k] * fb[k];
        if (s > hi) begin s = hi; st = 1'b1; end
        else if (s < lo) begin s = lo; st = 1'b1; end
      end
      if (CFG_FS[i] > 0) s = (s + (longint'(1) <<< (CFG_FS[i] - 1))) >>> CFG_FS[i];
      ohi = (longint'(1) <<< (CFG_WO[i] - 1)) - 1;
      if (s > ohi) begin s = ohi; st = 1'b1; end
      else if (s < -ohi - 1) begin s = -ohi - 1; st = 1'b1; end
      e.val[i] = 16'(s);
      e.sat[i] = st;
    end
    return e;
  endfunction

  // Monitor / scoreboard
  int          cyc = 0;
  logic        stall_prev = 1'b0;
  logic [15:0] held_out [4];
  logic [3:0]  held_sat;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    exp_t e;
    if (!resetn) begin
      check("rst_out_valid", ov, 0);
      check("rst_out_sat", os, 0);
      for (int i = 0; i < 4; i++) check($sformatf("rst_out%0d", i), outs[i], 0);
      fa.delete(); fb.delete(); expq.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", ov, 4'hf);
        check("hold_sat", os, held_sat);
        for (int i = 0; i < 4; i++) check($sformatf("hold_out%0d", i), outs[i], $signed(held_out[i]));
      end
      if (ov[0] && !out_ready) check("stall_in_ready", rdy, 4'h0);
      if (ov[0] && out_ready) begin
        if (expq.size() == 0) check("spurious_out_valid", ov[0], 0);
        else begin
          e = expq.pop_front();
          check("out_valid_all", ov, 4'hf);
          for (int i = 0; i < 4; i++) begin
            check($sformatf("out%0d", i), outs[i], $signed(e.val[i]));
            check($sformatf("out_sat%0d", i), os[i], e.sat[i]);
          end
          if (e.chk) check("latency", cyc - e.cyc, LAT);
        end
      end
      stall_prev = ov[0] && !out_ready;
      held_sat   = os;
      for (int i = 0; i < 4; i++) held_out[i] = outs[i];
      if (in_valid && rdy[0]) begin
        if (in_first) begin fa.delete(); fb.delete(); end
        fa.push_back(int'(in_a));
        fb.push_back(int'(in_b));
        if (in_last) begin
          expq.push_back(model_frame(cyc, chk_lat));
          fa.delete(); fb.delete();
        end
      end
    end
  end

  // out_ready driver: 0 always ready, 1 random, 2 low for a 5-cycle window
  int rdy_mode = 0, lo_start = 0;

  always @(posedge clock) begin
    #1;
    case (rdy_mode)
      1:       out_ready = ($urandom_range(0, 3) != 0);
      2:       out_ready = !(cyc >= lo_start && cyc < lo_start + 5);
      default: out_ready = 1'b1;
    endcase
  end

  task automatic send(input int a, input int b, input logic f, input logic l);
    int n = 0;
    in_valid = 1'b1; in_a = a[3:0]; in_b = b[4:0]; in_first = f; in_last = l;
    @(negedge clock);
    while (!rdy[0] && n < 200) begin
      n++;
      @(negedge clock);
    end
    if (n >= 200) check("in_ready_timeout", 0, 1);
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a, b, len;
    resetn = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;
    idle(2);

    // plain multiplies back-to-back, latency checked
    chk_lat = 1'b1;
    send(2, -15, 1, 1);
    send(-1, -1, 1, 1);
    send(-8, -11, 1, 1);
    idle(1);
    chk_lat = 1'b0;
    idle(8);

    // three-beat frame -> 59
    send(2, -15, 1, 0);
    send(-1, -1, 0, 0);
    send(-8, -11, 0, 1);
    idle(8);

    // four beats of -8*-16: overflows the GUARD=0 accumulator
    send(-8, -16, 1, 0);
    send(-8, -16, 0, 0);
    send(-8, -16, 0, 0);
    send(-8, -16, 0, 1);
    idle(8);

    // backpressure window over a continuous single-beat stream
    lo_start = cyc + 8;
    rdy_mode = 2;
    for (int k = 0; k < 12; k++)
      send(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 31)) - 16, 1, 1);
    idle(10);
    rdy_mode = 0;

    // reset mid-frame, then fresh frames
    send(7, 15, 1, 0);
    send(7, 15, 0, 0);
    in_valid = 1'b0;
    #2 resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    send(3, 3, 1, 1);
    send(1, 1, 0, 1);
    idle(8);

    // random frames with random gaps and random out_ready
    rdy_mode = 1;
    for (int f = 0; f < 200; f++) begin
      len = int'($urandom_range(1, 6));
      for (int k = 0; k < len; k++) begin
        a = int'($urandom_range(0, 15)) - 8;
        b = int'($urandom_range(0, 31)) - 16;
        send(a, b, (k == 0), (k == len - 1));
      end
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(1);
    rdy_mode = 0;
    idle(20);
    check("drain_empty", expq.size(), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
